// File: rtl/config_loader_pkg.sv
// config_loader_pkg
//   Shared constants and types for the configuration frame loader:
//   the sync word, header bit-field positions, the loader state enum and
//   a small address range helper.
package config_loader_pkg;

   localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

   // Header word layout; all other header bits are ignored.
   localparam int DESYNC_BIT = 31;
   localparam int COL_MSB    = 15;
   localparam int COL_LSB    = 8;
   localparam int FRAME_MSB  = 4;
   localparam int FRAME_LSB  = 0;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      DATA,
      CHECK,
      STROBE
   } state_e;

   // True when the header addresses an existing column/frame.
   function automatic logic addr_in_range(input logic [7:0] col,
                                          input logic [4:0] frame,
                                          input int         num_cols,
                                          input int         max_frames);
      return (int'(col) < num_cols) && (int'(frame) < max_frames);
   endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// frame_strobe_decoder
//   Combinational column/frame to one-hot strobe decoder.
//   Ports:
//     col_i    - column address from the frame header
//     frame_i  - frame index from the frame header
//     en_i     - strobe enable (frame valid and complete)
//     strobe_o - NumColumns*MaxFramesPerCol one-hot vector; bit
//                c*MaxFramesPerCol+f for column c frame f; all zero when
//                disabled or when the address is out of range.
module frame_strobe_decoder #(
   parameter int NumColumns      = 4,
   parameter int MaxFramesPerCol = 20
) (
   input  logic [7:0]                            col_i,
   input  logic [4:0]                            frame_i,
   input  logic                                  en_i,
   output logic [NumColumns*MaxFramesPerCol-1:0] strobe_o
);

   // Shifting past the top of the slice truncates to zero, so an
   // out-of-range frame index yields no strobe without an explicit compare.
   logic [MaxFramesPerCol-1:0] frame_onehot;
   assign frame_onehot = MaxFramesPerCol'(1) << frame_i;

   // A column address >= NumColumns matches no slice.
   for (genvar c = 0; c < NumColumns; c++) begin : g_col
      assign strobe_o[c*MaxFramesPerCol +: MaxFramesPerCol] =
         (en_i && (col_i == 8'(c))) ? frame_onehot : '0;
   end

endmodule

// File: rtl/config_frame_loader.sv
// config_frame_loader
//   Unpacks a 32-bit bitstream word stream into configuration frames and
//   fires a single-cycle FrameStrobe for the addressed column/frame.
//   Stream: IDLE waits for SYNC_WORD; then each header is followed by
//   NumRows data words (plus one XOR checksum word when CONFIG_CHECKSUM_EN
//   is defined), then one STROBE cycle with s_ready low.
//   Ports:
//     CLK, RST     - clock, asynchronous active-high reset
//     s_data       - bitstream word
//     s_valid      - word valid
//     s_ready      - word accepted when s_valid && s_ready (state-only)
//     FrameData    - row k at [k*32 +: 32]; changes only on DATA words
//     FrameStrobe  - registered one-hot column/frame strobe
//     ConfigBusy   - loader is not in IDLE
//     ConfigError  - sticky error, cleared by the next SYNC_WORD
//   Build option: CONFIG_CHECKSUM_EN adds the CHECK state and the trailing
//   checksum word per frame.
module config_frame_loader
   import config_loader_pkg::*;
#(
   parameter int NumColumns      = 4,
   parameter int NumRows         = 4,
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic [31:0]                           s_data,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
   output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
   output logic                                  ConfigBusy,
   output logic                                  ConfigError
);

   localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
   localparam int SW = NumColumns * MaxFramesPerCol;
   localparam int FW = NumRows * FrameBitsPerRow;

   state_e                 state_q, state_d;
   logic [7:0]             col_q, col_d;
   logic [4:0]             frame_q, frame_d;
   logic [RW-1:0]          row_q, row_d;
   logic                   ok_q, ok_d;
   logic                   err_q, err_d;
   logic [FW-1:0]          data_q, data_d;
   logic [SW-1:0]          strobe_q, strobe_d;
   logic                   strobe_en;
   logic                   acc;
`ifdef CONFIG_CHECKSUM_EN
   logic [31:0]            csum_q, csum_d;
`endif

   // Ready is a function of state only (and forced low during reset).
   assign s_ready     = ~RST & (state_q != STROBE);
   assign acc         = s_valid & s_ready;
   assign FrameData   = data_q;
   assign FrameStrobe = strobe_q;
   assign ConfigBusy  = (state_q != IDLE);
   assign ConfigError = err_q;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      frame_d   = frame_q;
      row_d     = row_q;
      ok_d      = ok_q;
      err_d     = err_q;
      data_d    = data_q;
      strobe_en = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (acc && (s_data == SYNC_WORD)) begin
               state_d = HEADER;
               err_d   = 1'b0;
            end
         end
         HEADER: begin
            if (acc) begin
               if (s_data[DESYNC_BIT]) begin
                  state_d = IDLE;
               end else begin
                  col_d   = s_data[COL_MSB:COL_LSB];
                  frame_d = s_data[FRAME_MSB:FRAME_LSB];
                  row_d   = '0;
                  ok_d    = addr_in_range(s_data[COL_MSB:COL_LSB],
                                          s_data[FRAME_MSB:FRAME_LSB],
                                          NumColumns, MaxFramesPerCol);
                  if (!ok_d) err_d = 1'b1;
`ifdef CONFIG_CHECKSUM_EN
                  csum_d  = '0;
`endif
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (acc) begin
               data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
               row_d = row_q + RW'(1);
`ifdef CONFIG_CHECKSUM_EN
               csum_d = csum_q ^ s_data;
               if (row_q == RW'(NumRows-1)) state_d = CHECK;
`else
               if (row_q == RW'(NumRows-1)) begin
                  state_d   = STROBE;
                  strobe_en = ok_q;
               end
`endif
            end
         end
`ifdef CONFIG_CHECKSUM_EN
         CHECK: begin
            if (acc) begin
               if (s_data != csum_q) begin
                  ok_d  = 1'b0;
                  err_d = 1'b1;
               end else begin
                  strobe_en = ok_q;
               end
               state_d = STROBE;
            end
         end
`endif
         STROBE:  state_d = HEADER;
         default: state_d = IDLE;
      endcase
   end

   // Decode in the accepting cycle; the registered result lines up with
   // the single STROBE cycle.
   frame_strobe_decoder #(
      .NumColumns      (NumColumns),
      .MaxFramesPerCol (MaxFramesPerCol)
   ) u_dec (
      .col_i    (col_q),
      .frame_i  (frame_q),
      .en_i     (strobe_en),
      .strobe_o (strobe_d)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         col_q    <= '0;
         frame_q  <= '0;
         row_q    <= '0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         data_q   <= '0;
         strobe_q <= '0;
`ifdef CONFIG_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         frame_q  <= frame_d;
         row_q    <= row_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
`ifdef CONFIG_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_config_frame_loader.sv
// tb_config_frame_loader
//   Directed bench for config_frame_loader with a per-cycle reference
//   model and literal spot checks. Honours CONFIG_CHECKSUM_EN.
module tb_config_frame_loader;

   localparam int NC = 4;
   localparam int NR = 4;
   localparam int MF = 20;
   localparam int FW = NR * 32;
   localparam int SW = NC * MF;
   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

   localparam int M_IDLE = 0, M_HEADER = 1, M_DATA = 2, M_CHECK = 3, M_STROBE = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [31:0]   s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [FW-1:0] FrameData;
   logic [SW-1:0] FrameStrobe;
   logic          ConfigBusy;
   logic          ConfigError;

   config_frame_loader #(
      .NumColumns(NC), .NumRows(NR), .FrameBitsPerRow(32), .MaxFramesPerCol(MF)
   ) dut (
      .CLK(CLK), .RST(RST), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .FrameData(FrameData), .FrameStrobe(FrameStrobe),
      .ConfigBusy(ConfigBusy), .ConfigError(ConfigError)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   bit gap_en = 0;
   int cnt43 = 0;
   int cnt_pulses = 0;
   int last_idx = -1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_state;
   int          m_col, m_frame, m_row;
   logic [31:0] m_xor;
   bit          m_ok, m_err;
   logic [31:0] m_data [NR];

   always @(posedge CLK or posedge RST) begin : model_upd
      bit acc;
      if (RST) begin
         m_state = M_IDLE;
         m_err   = 0;
         m_ok    = 0;
         m_col   = 0;
         m_frame = 0;
         m_row   = 0;
         m_xor   = '0;
         foreach (m_data[i]) m_data[i] = '0;
      end else begin
         acc = s_valid && (m_state != M_STROBE);
         case (m_state)
            M_IDLE:
               if (acc && s_data == SYNC) begin m_state = M_HEADER; m_err = 0; end
            M_HEADER:
               if (acc) begin
                  if (s_data[31]) m_state = M_IDLE;
                  else begin
                     m_col   = int'(s_data[15:8]);
                     m_frame = int'(s_data[4:0]);
                     m_row   = 0;
                     m_xor   = '0;
                     m_ok    = (m_col < NC) && (m_frame < MF);
                     if (!m_ok) m_err = 1;
                     m_state = M_DATA;
                  end
               end
            M_DATA:
               if (acc) begin
                  m_data[m_row] = s_data;
                  m_xor = m_xor ^ s_data;
                  m_row++;
`ifdef CONFIG_CHECKSUM_EN
                  if (m_row == NR) m_state = M_CHECK;
`else
                  if (m_row == NR) m_state = M_STROBE;
`endif
               end
            M_CHECK:
               if (acc) begin
                  if (s_data != m_xor) begin m_ok = 0; m_err = 1; end
                  m_state = M_STROBE;
               end
            default: m_state = M_HEADER;
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin : compare
      logic [SW-1:0] es;
      logic [FW-1:0] ed;
      if (chk_en) begin
         es = '0;
         if (m_state == M_STROBE && m_ok) es[m_col*MF + m_frame] = 1'b1;
         for (int k = 0; k < NR; k++) ed[k*32 +: 32] = m_data[k];
         chk("s_ready",     128'(s_ready),     128'(!RST && m_state != M_STROBE));
         chk("ConfigBusy",  128'(ConfigBusy),  128'(m_state != M_IDLE));
         chk("ConfigError", 128'(ConfigError), 128'(m_err));
         chk("FrameData",   128'(FrameData),   128'(ed));
         chk("FrameStrobe", 128'(FrameStrobe), 128'(es));
         chk("strobe_onehot", 128'($countones(FrameStrobe) <= 1), 128'(1));
         if (FrameStrobe != '0) begin
            cnt_pulses++;
            for (int b = 0; b < SW; b++) if (FrameStrobe[b]) last_idx = b;
         end
         if (FrameStrobe[43]) cnt43++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      bit rdy;
      rdy = 0;
      if (gap_en && $urandom_range(0, 2) == 0) begin
         s_valid = 1'b0;
         s_data  = $urandom;
         repeat ($urandom_range(1, 3)) @(posedge CLK);
         #1;
      end
      s_data  = w;
      s_valid = 1'b1;
      for (int i = 0; i < 40 && !rdy; i++) begin
         @(negedge CLK);
         rdy = s_ready;
         @(posedge CLK);
         #1;
      end
      s_valid = 1'b0;
      checks++;
      if (!rdy) begin
         errors++;
         $display("FAIL handshake: word %h not accepted within 40 cycles", w);
      end
   endtask

   task automatic send_frame(input logic [31:0] hdr, input logic [31:0] d0,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] d3, input bit bad_csum);
      send_word(hdr);
      send_word(d0);
      send_word(d1);
      send_word(d2);
      send_word(d3);
`ifdef CONFIG_CHECKSUM_EN
      send_word(bad_csum ? 32'h0 : (d0 ^ d1 ^ d2 ^ d3));
`else
      if (bad_csum) checks += 0;
`endif
   endtask

   initial begin
      idle(1);
      chk_en = 1;
      idle(2);
      RST = 1'b0;
      idle(1);
      // reset state
      chk("rst_FrameData", 128'(FrameData), 128'(0));
      chk("rst_busy",      128'(ConfigBusy), 128'(0));
      chk("rst_ready",     128'(s_ready),    128'(1));

      // garbage before sync is discarded
      send_word(32'hDEADBEEF);
      send_word(32'h12345678);
      idle(1);
      chk("pre_sync_busy",   128'(ConfigBusy), 128'(0));
      chk("pre_sync_data",   128'(FrameData),  128'(0));
      chk("pre_sync_pulses", 128'(cnt_pulses), 128'(0));

      // basic frame col 2 frame 3 -> bit 43
      send_word(SYNC);
      send_frame(32'h0000_0203, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0);
      idle(2);
      chk("f1_data",  128'(FrameData), {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      chk("f1_cnt43", 128'(cnt43), 128'(1));
      chk("f1_err",   128'(ConfigError), 128'(0));

      // column out of range: words consumed, no strobe, sticky error
      send_frame(32'h0000_0400, 32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333, 0);
      idle(2);
      chk("col4_err",    128'(ConfigError), 128'(1));
      chk("col4_pulses", 128'(cnt_pulses), 128'(1));
      chk("col4_busy",   128'(ConfigBusy), 128'(1));

      // desync back to IDLE; following frame ignored until sync
      send_word(32'h8000_0000);
      idle(1);
      chk("desync_busy", 128'(ConfigBusy), 128'(0));
      chk("desync_err",  128'(ConfigError), 128'(1));
      send_frame(32'h0000_0101, 32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3, 0);
      idle(1);
      chk("ignored_data", 128'(FrameData), {32'hA3333333, 32'hA2222222, 32'hA1111111, 32'hA0000000});
      chk("ignored_pulses", 128'(cnt_pulses), 128'(1));
      send_word(SYNC);
      idle(1);
      chk("resync_err", 128'(ConfigError), 128'(0));

`ifdef CONFIG_CHECKSUM_EN
      // bad checksum: no strobe, error; next header accepted normally
      send_frame(32'h0000_0203, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1);
      idle(2);
      chk("badck_err",    128'(ConfigError), 128'(1));
      chk("badck_pulses", 128'(cnt_pulses), 128'(1));
`endif
      // frame index out of range (20): error, no strobe
      send_frame(32'h0000_0014, 32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 0);
      idle(2);
      chk("frm20_err",    128'(ConfigError), 128'(1));
      chk("frm20_pulses", 128'(cnt_pulses), 128'(1));
      // highest address: column 3 frame 19 -> bit 79
      send_frame(32'h0000_0313, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 0);
      idle(2);
      chk("edge_idx",    128'(last_idx), 128'(79));
      chk("edge_pulses", 128'(cnt_pulses), 128'(2));

      // reset after the second data word aborts the frame
      send_word(32'h0000_0105);
      send_word(32'hD0D0D0D0);
      send_word(32'hD1D1D1D1);
      RST = 1'b1;
      idle(2);
      chk("mid_rst_data",  128'(FrameData), 128'(0));
      chk("mid_rst_err",   128'(ConfigError), 128'(0));
      chk("mid_rst_busy",  128'(ConfigBusy), 128'(0));
      chk("mid_rst_ready", 128'(s_ready), 128'(0));
      chk("mid_rst_pulses", 128'(cnt_pulses), 128'(2));
      RST = 1'b0;
      idle(1);

      // first scenario again with random valid gaps
      gap_en = 1;
      send_word(32'h0000_0777);
      send_word(SYNC);
      send_frame(32'h0000_0203, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0);
      idle(3);
      chk("gap_data",  128'(FrameData), {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      chk("gap_cnt43", 128'(cnt43), 128'(2));
      chk("gap_pulses", 128'(cnt_pulses), 128'(3));
      chk("gap_err",   128'(ConfigError), 128'(0));

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
